// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_pkg
//  Description : Shared definitions for the FIFO-fed UART blocks. Holds the
//                FSM state encoding, the oversampling ratio and helpers that
//                derive the baud divider, so a companion RX block can reuse
//                exactly the same constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    // Ticks per serial bit (16x oversampling).
    localparam int OVERSAMPLE = 16;

    // Datapath / counter widths.
    localparam int DATA_W     = 8;
    localparam int TICK_CNT_W = 4;
    localparam int BIT_IDX_W  = 3;

    // Frame FSM encoding, shared with the receive side.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Clocks per oversampling tick (integer division, truncating).
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : fifo_uart_pkg
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Oversampling tick generator. Emits a single-clock tick every
//                DIV = CLK_FREQ/(BAUD*16) clocks. 'clr' restarts the period so
//                the first tick lands exactly DIV clocks after the clear.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk   in   system clock, rising edge
//    rst   in   asynchronous active-high reset
//    clr   in   restart the divider (counter back to 0 on next edge)
//    tick  out  one-clock strobe, high in the last clock of each period
// ============================================================================
module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    // A divider below one would be meaningless; clamp so the block then
    // ticks every clock instead of never.
    localparam int DIV_RAW = calc_div(CLK_FREQ, BAUD);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CNT_W   = cnt_width(DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : 8N1 UART transmitter fed from a first-word-fall-through FIFO.
//                In IDLE it pops one byte whenever the FIFO is non-empty,
//                latches it and sends start bit, 8 data bits (LSB first) and
//                a stop bit, each lasting 16 oversampling ticks.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk         in   system clock, rising edge
//    rst         in   asynchronous active-high reset
//    fifo_empty  in   upstream FIFO empty flag
//    fifo_rdata  in   [7:0] FIFO head word, valid while fifo_empty=0
//    fifo_pop    out  one-clock pop strobe to the FIFO
//    tx          out  serial line, idle high, registered
//    tx_busy     out  high whenever a frame is in progress
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_pop,
    output logic              tx,
    output logic              tx_busy
);

    localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(OVERSAMPLE - 1);
    localparam logic [TICK_CNT_W-1:0] TICK_ONE  = TICK_CNT_W'(1);
    localparam logic [BIT_IDX_W-1:0]  IDX_LAST  = BIT_IDX_W'(DATA_W - 1);
    localparam logic [BIT_IDX_W-1:0]  IDX_ONE   = BIT_IDX_W'(1);

    uart_state_t           state_q,    state_d;
    logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [BIT_IDX_W-1:0]  bit_idx_q,  bit_idx_d;
    logic [DATA_W-1:0]     shift_q,    shift_d;
    logic                  tx_q,       tx_d;

    logic tick;
    logic bit_end;
    logic pop_req;

    // ------------------------------------------------------------------------
    // Oversampling tick source; restarted on every pop so the start bit is
    // exactly 16 full tick periods long.
    // ------------------------------------------------------------------------
    baud_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (pop_req),
        .tick (tick)
    );

    // Last tick of the current bit period.
    assign bit_end = tick && (tick_cnt_q == TICK_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop_req    = 1'b0;

        // Tick count advances on every tick outside IDLE and wraps 15->0
        // on its own at the end of each bit.
        if ((state_q != ST_IDLE) && tick) begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_req    = 1'b1;
                    shift_d    = fifo_rdata;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level is computed from the upcoming state so the registered
        // tx changes on the same edge as the FSM.
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[bit_idx_d];
            default:  tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx      = tx_q;
    assign tx_busy = (state_q != ST_IDLE);
    // The FSM sits in IDLE during reset; gating keeps a non-empty FIFO from
    // seeing a pop strobe while reset is held.
    assign fifo_pop = pop_req && !rst;

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Self-checking bench for fifo_uart_tx. A queue plays the
//                upstream FWFT FIFO; a frame-level model predicts pop, tx and
//                tx_busy every clock from the byte popped and the clocks
//                elapsed since the pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int DIV      = CLK_FREQ / (BAUD * 16);
    localparam int BIT_CLKS = 16 * DIV;
    localparam int FRAME    = 10 * BIT_CLKS;
    localparam int LIMIT    = 6000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];
    logic [7:0] pend[$];
    int         pop_cyc[$];
    int         cyc      = 0;
    int         busy_cnt = 0;
    int         low_cnt  = 0;

    bit         m_active  = 1'b0;
    int         m_off     = 0;
    logic [7:0] m_byte    = 8'h00;
    bit         m_pop_exp = 1'b0;
    bit         pop_seen  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : 8'($urandom);
    endtask

    // Expected line level: start bit for the first bit period after the pop,
    // then data LSB first, then stop / idle high.
    function automatic logic exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = (m_off - 1) / BIT_CLKS;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        pend.push_back(b);
    endtask

    task automatic step();
        logic exp_pop;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_active = 1'b0;
        end else if (m_pop_exp && fq.size() != 0) begin
            m_active = 1'b1;
            m_off    = 1;
            m_byte   = fq[0];
        end else if (m_active) begin
            if (m_off == FRAME) m_active = 1'b0;
            else m_off++;
        end
        if (pop_seen && fq.size() != 0) void'(fq.pop_front());
        while (pend.size() != 0) fq.push_back(pend.pop_front());
        drive_fifo();

        @(negedge clk);
        exp_pop = !rst && !m_active && (fq.size() != 0);
        check_eq("pop", fifo_pop, exp_pop);
        check_eq("tx", tx, exp_tx());
        check_eq("busy", tx_busy, !rst && m_active);
        m_pop_exp = exp_pop;
        pop_seen  = fifo_pop;
        if (fifo_pop) pop_cyc.push_back(cyc);
        if (tx_busy) busy_cnt++;
        if (!tx) low_cnt++;
    endtask

    task automatic release_rst();
        rst = 1'b0;
        #1;
        m_pop_exp = (fq.size() != 0);
        pop_seen  = fifo_pop;
        check_eq("pop_at_release", fifo_pop, m_pop_exp);
        if (fifo_pop) pop_cyc.push_back(cyc);
    endtask

    task automatic assert_rst_async();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_pop", fifo_pop, 0);
        m_pop_exp = 1'b0;
        pop_seen  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            step();
            n++;
        end while ((m_active || fq.size() != 0 || pend.size() != 0) && n < LIMIT);
        check_eq("idle_reached", tx_busy, 0);
    endtask

    initial begin
        int pc0;
        int b0;
        int n;

        // Reset held with a byte waiting: no pop, idle outputs.
        push(8'h11);
        for (int i = 0; i < 5; i++) step();
        release_rst();
        wait_idle();

        // Single byte 0xA5.
        pc0 = pop_cyc.size();
        b0  = busy_cnt;
        push(8'hA5);
        wait_idle();
        check_eq("a5_pops", pop_cyc.size() - pc0, 1);
        check_eq("a5_busy_clks", busy_cnt - b0, FRAME);

        // Back-to-back 0x55, 0x0F.
        pc0 = pop_cyc.size();
        push(8'h55);
        push(8'h0F);
        wait_idle();
        check_eq("b2b_pops", pop_cyc.size() - pc0, 2);
        if (pop_cyc.size() >= pc0 + 2)
            check_eq("b2b_gap", pop_cyc[pc0+1] - pop_cyc[pc0], FRAME + 1);

        // Long empty period.
        pc0 = pop_cyc.size();
        b0  = low_cnt;
        for (int i = 0; i < 5000; i++) step();
        check_eq("empty_pops", pop_cyc.size() - pc0, 0);
        check_eq("empty_tx_low", low_cnt - b0, 0);

        // Reset in the middle of data bit 3 of 0xC3 (bit 3 is 0).
        push(8'hC3);
        n = 0;
        while (!(m_active && m_off == 4 * BIT_CLKS + 80) && n < LIMIT) begin
            step();
            n++;
        end
        check_eq("c3_bit3_level", tx, 0);
        assert_rst_async();
        for (int i = 0; i < 3; i++) step();
        release_rst();
        pc0 = pop_cyc.size();
        for (int i = 0; i < 300; i++) step();
        check_eq("c3_no_repop", pop_cyc.size() - pc0, 0);

        // Byte arriving mid-frame waits for the first IDLE clock.
        pc0 = pop_cyc.size();
        push(8'h3C);
        for (int i = 0; i < 800; i++) step();
        push(8'h81);
        wait_idle();
        check_eq("mid_pops", pop_cyc.size() - pc0, 2);
        if (pop_cyc.size() >= pc0 + 2)
            check_eq("mid_gap", pop_cyc[pc0+1] - pop_cyc[pc0], FRAME + 1);

        // Randomised traffic.
        for (int r = 0; r < 6; r++) begin
            push(8'($urandom));
            if ($urandom_range(0, 1) == 1) push(8'($urandom));
            n = $urandom_range(0, 2000);
            for (int i = 0; i < n; i++) step();
            if ($urandom_range(0, 1) == 1) push(8'($urandom));
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_uart_tx
`default_nettype wire
